// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, sticky error flags, replace-top and flush.
// Entry count-1 is the top; storage is unreset and validity comes only from count.
module param_stack_entry #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module param_stack #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_en;
  logic [CW-1:0]               wr_idx;
  logic                        op;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign op    = !rst && !clear;

  // Push-only writes above the top; push+pop overwrites the top in place.
  assign wr_en  = op && push && (pop ? !empty : !full);
  assign wr_idx = pop ? count - CW'(1) : count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    param_stack_entry #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .we  (wr_en && (wr_idx == CW'(i))),
      .d   (push_data),
      .q   (mem[i])
    );
  end

  // Matching count==i+1 selects the top and naturally yields 0 when empty.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count == CW'(i + 1)) top = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      pop_data  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b11: pop_data <= empty ? push_data : top;
        2'b10: begin
          if (full) overflow <= 1'b1;
          else      count    <= count + CW'(1);
        end
        2'b01: begin
          if (empty) underflow <= 1'b1;
          else begin
            pop_data <= top;
            count    <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: queue-based reference model checked every cycle,
// plus directed literal expectations from the test plan.
module tb_param_stack;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, push, pop, clear;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] pop_data, top;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
    .push_data(push_data), .pop_data(pop_data), .top(top), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_pop;
  logic             m_ov, m_un;
  logic             m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_pop = '0; m_ov = 1'b0; m_un = 1'b0; m_valid = 1'b1;
    end else if (clear) begin
      mq.delete(); m_ov = 1'b0; m_un = 1'b0;
    end else if (push && pop) begin
      if (mq.size() == 0) m_pop = push_data;
      else begin
        m_pop = mq[mq.size()-1];
        mq[mq.size()-1] = push_data;
      end
    end else if (push) begin
      if (mq.size() == DEPTH) m_ov = 1'b1;
      else mq.push_back(push_data);
    end else if (pop) begin
      if (mq.size() == 0) m_un = 1'b1;
      else m_pop = mq.pop_back();
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs depend only on state, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_count", count, mq.size());
      chk("m_empty", empty, mq.size() == 0);
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_top", top, (mq.size() == 0) ? 0 : mq[mq.size()-1]);
      chk("m_pop_data", pop_data, m_pop);
      chk("m_overflow", overflow, m_ov);
      chk("m_underflow", underflow, m_un);
    end
  end

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic step(input logic ps, input logic pp, input logic cl,
                      input logic rs, input logic [WIDTH-1:0] d);
    push = ps; pop = pp; clear = cl; rst = rs; push_data = d;
    @(negedge clk);
    push = 0; pop = 0; clear = 0; rst = 0;
  endtask

  initial begin
    push = 0; pop = 0; clear = 0; rst = 0; push_data = '0;
    @(negedge clk);
    step(0, 0, 0, 1, 0);
    chk("rst_pop_data", pop_data, 0); chk("rst_top", top, 0);
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_full", full, 0); chk("rst_ov", overflow, 0); chk("rst_un", underflow, 0);

    // Fill / overflow / drain
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 12'(i));
    chk("fill_count", count, 8); chk("fill_full", full, 1); chk("fill_top", top, 8);
    step(1, 0, 0, 0, 12'd9);
    chk("ovf_flag", overflow, 1); chk("ovf_count", count, 8); chk("ovf_top", top, 8);
    for (int i = 8; i >= 1; i--) begin
      step(0, 1, 0, 0, 0);
      chk("drain_pop_data", pop_data, i);
    end
    chk("drain_ov_sticky", overflow, 1);
    chk("drain_empty", empty, 1); chk("drain_count", count, 0);

    // Underflow, then clear
    step(0, 1, 0, 0, 0);
    chk("unf_flag", underflow, 1); chk("unf_pop_data", pop_data, 1); chk("unf_count", count, 0);
    step(0, 0, 1, 0, 0);
    chk("clr_un", underflow, 0); chk("clr_ov", overflow, 0);

    // Replace-top and empty pass-through
    step(1, 0, 0, 0, 12'd5); step(1, 0, 0, 0, 12'd6);
    step(1, 1, 0, 0, 12'hABC);
    chk("rt_pop_data", pop_data, 6); chk("rt_top", top, 12'hABC); chk("rt_count", count, 2);
    step(0, 1, 0, 0, 0); chk("rt_pop1", pop_data, 12'hABC);
    step(0, 1, 0, 0, 0); chk("rt_pop2", pop_data, 5);
    step(1, 1, 0, 0, 12'h123);
    chk("pt_pop_data", pop_data, 12'h123); chk("pt_count", count, 0);
    chk("pt_ov", overflow, 0); chk("pt_un", underflow, 0);

    // Full replace-top does not flag overflow
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 12'(16 + i));
    step(1, 1, 0, 0, 12'h77);
    chk("frt_pop_data", pop_data, 23); chk("frt_top", top, 12'h77);
    chk("frt_ov", overflow, 0); chk("frt_count", count, 8);

    // Reset mid-operation with concurrent push
    step(1, 0, 0, 0, 12'h1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("mid_pre_count", count, 5); chk("mid_pre_ov", overflow, 1);
    step(1, 0, 0, 1, 12'h55);
    chk("mid_count", count, 0); chk("mid_pop_data", pop_data, 0);
    chk("mid_ov", overflow, 0); chk("mid_un", underflow, 0);
    chk("mid_empty", empty, 1); chk("mid_top", top, 0);
    step(1, 0, 0, 0, 12'h7);
    chk("post_top", top, 12'h7); chk("post_count", count, 1);

    // Clear beats push and pop
    step(1, 0, 0, 0, 12'h8); step(1, 0, 0, 0, 12'h9);
    step(0, 1, 0, 0, 0); step(1, 0, 0, 0, 12'hA);
    chk("cp_pre_count", count, 3);
    step(1, 1, 1, 0, 12'hFFF);
    chk("cp_count", count, 0); chk("cp_pop_data", pop_data, 9);
    chk("cp_ov", overflow, 0); chk("cp_un", underflow, 0);

    // Pseudo-random traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      step(r < 7, (r >= 5 && r < 12), r == 15, 1'b0, 12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/param_stack.md
# param_stack

Parametrised LIFO stack for the pipeline's buffering needs (return-address and scratch storage), succeeding the fixed 12-bit stack. Width and depth are parameters. It adds empty/full/count status, a combinational top-of-stack peek, and separate sticky overflow/underflow flags. It also supports simultaneous push+pop (replace-top) and a synchronous flush.

## Interface
- WIDTH, 12, data width in bits (>=1)
- DEPTH, 8, number of entries (>=2, need not be a power of two)
- CW (localparam), $clog2(DEPTH+1), width of `count`

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- push  in  1  push request
- pop  in  1  pop request
- clear  in  1  synchronous flush (empties stack, clears flags)
- push_data  in  WIDTH  data to push
- pop_data  out  WIDTH  registered value returned by the most recent accepted pop
- top  out  WIDTH  combinational peek of current top entry; 0 when empty
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Storage: DEPTH x WIDTH register array. Entry index `count-1` is the top. The array is not reset; only `count` defines validity.
- Per-edge priority: rst > clear > push/pop.
- rst: count=0, pop_data=0, overflow=0, underflow=0.
- clear (rst low): count=0, overflow=0, underflow=0. pop_data holds. push/pop in the same cycle are ignored.
- Push only:
  - not full: mem[count] <= push_data; count+1.
  - full: data dropped, count unchanged, overflow <= 1.
- Pop only:
  - not empty: pop_data <= mem[count-1]; count-1.
  - empty: pop_data holds, underflow <= 1.
- Push and pop together:
  - not empty (including full): replace-top. pop_data <= mem[count-1]; mem[count-1] <= push_data; count unchanged. No overflow is flagged.
  - empty: pass-through. pop_data <= push_data; count stays 0. No flag is set.
- Neither asserted: state holds.
- overflow/underflow stay set until rst or clear. New events never clear them.
- empty, full and top are derived combinationally from count and the array.
- count never exceeds DEPTH and never wraps below 0.

## Timing
- All state updates on the rising edge of clk. Single-cycle latency: pop_data is valid the cycle after the pop is sampled.
- top reflects a push or pop from the following cycle. Back-to-back push/pop every cycle is supported with no bubbles.
- Flags assert on the edge that samples the rejected request and are visible the next cycle.
- Reset mid-operation: the next cycle shows count=0, empty=1, full=0, top=0, pop_data=0, and both flags 0, regardless of concurrent push/pop.
- Outputs after reset: pop_data=0, top=0, count=0, empty=1, full=0, overflow=0, underflow=0.

## Test plan
- Fill/drain (WIDTH=12, DEPTH=8): push 1..8 on consecutive cycles -> count=8, full=1, top=8. Then pop 8 times -> pop_data reads 8,7,…,1 on the cycles after each pop; empty=1 and count=0 at the end.
- Overflow: with the stack full of 1..8, push 9 -> overflow=1, count=8, top=8. Pop -> pop_data=8 and overflow still 1.
- Underflow: on the empty stack with pop_data=1, pop -> underflow=1, pop_data stays 1, count=0. Then clear -> underflow=0, overflow=0.
- Simultaneous: stack holds 5,6 (top=6); push=pop=1 with push_data=0xABC -> pop_data=6, top=0xABC, count=2. On the empty stack, push=pop=1 with 0x123 -> pop_data=0x123, count=0, no flags set.
- Reset mid-operation: with count=5 and overflow=1, assert rst together with push=1 -> next cycle count=0, pop_data=0, flags 0, empty=1. A subsequent push of 0x7 gives top=0x7, count=1.
- Clear priority: with count=3, assert clear, push and pop in the same cycle -> count=0, pop_data unchanged, no flags set.
